// File: rtl/bpred_fetch_stage_if.sv
// Fetch-stage bus: pipeline control, branch-resolution feedback,
// instruction-memory address/data and the registered IF/ID payload.
//   master : drives control/update/instruction, observes PC and IF/ID
//   slave  : the fetch stage itself
interface bpred_fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  // pipeline control
  logic            PCWrite;
  logic            IF_ID_Write;
  logic            Exception;
  logic            Mispredict;
  logic [XLEN-1:0] CorrectPC;
  // branch resolution from decode
  logic            UpdValid;
  logic [XLEN-1:0] UpdPC;
  logic            UpdTaken;
  logic [XLEN-1:0] UpdTarget;
  // instruction memory
  logic [XLEN-1:0] PCResult;
  logic [31:0]     Instruction;
  // IF/ID register
  logic [31:0]     IF_ID_Instruction;
  logic [XLEN-1:0] IF_ID_PCadderResult;
  logic            IF_ID_PredTaken;
  logic [XLEN-1:0] IF_ID_PredTarget;
  logic            IF_ID_Valid;

  modport master (
    output PCWrite, IF_ID_Write, Exception, Mispredict, CorrectPC,
           UpdValid, UpdPC, UpdTaken, UpdTarget, Instruction,
    input  PCResult, IF_ID_Instruction, IF_ID_PCadderResult,
           IF_ID_PredTaken, IF_ID_PredTarget, IF_ID_Valid
  );

  modport slave (
    input  PCWrite, IF_ID_Write, Exception, Mispredict, CorrectPC,
           UpdValid, UpdPC, UpdTaken, UpdTarget, Instruction,
    output PCResult, IF_ID_Instruction, IF_ID_PCadderResult,
           IF_ID_PredTaken, IF_ID_PredTarget, IF_ID_Valid
  );
endinterface

// File: rtl/bpred_fetch_stage.sv
// Instruction-fetch stage with a direct-mapped BTB and 2-bit saturating
// predictor. Prediction is combinational on the current PC; the IF/ID
// register carries the prediction to decode, which feeds resolved branches
// back through the update and mispredict signals.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - bpred_fetch_stage_if.slave (control, update, imem, IF/ID)
module bpred_fetch_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ENTRIES    = 16,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(32'h0000_0100),
  parameter logic [1:0]      CTR_INIT   = 2'b01
) (
  input logic                   clk,
  input logic                   rst,
  bpred_fetch_stage_if.slave    bus
);

  localparam int unsigned IW   = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IW - 2;

  // BTB / predictor storage
  logic            btb_valid_q [ENTRIES];
  logic [TAGW-1:0] btb_tag_q   [ENTRIES];
  logic [XLEN-1:0] btb_tgt_q   [ENTRIES];
  logic [1:0]      btb_ctr_q   [ENTRIES];

  logic [XLEN-1:0] pc_q, pc_d;

  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_pt_q, ifid_pt_d;
  logic [XLEN-1:0] ifid_tgt_q, ifid_tgt_d;
  logic            ifid_valid_q, ifid_valid_d;

  // Lookup on the current PC
  logic [IW-1:0]   lk_idx_c;
  logic [TAGW-1:0] lk_tag_c;
  logic            lk_hit_c;
  logic            pred_taken_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] pred_next_c;
  logic            flush_c;

  assign lk_idx_c     = pc_q[IW+1:2];
  assign lk_tag_c     = pc_q[XLEN-1:IW+2];
  assign lk_hit_c     = btb_valid_q[lk_idx_c] && (btb_tag_q[lk_idx_c] == lk_tag_c);
  assign pred_taken_c = lk_hit_c && btb_ctr_q[lk_idx_c][1];
  assign pc_plus4_c   = pc_q + XLEN'(4);
  assign pred_next_c  = pred_taken_c ? btb_tgt_q[lk_idx_c] : pc_plus4_c;
  assign flush_c      = bus.Exception | bus.Mispredict;

  // Byte-offset bits never take part in indexing or tagging
  logic unused_c;
  assign unused_c = ^{pc_q[1:0], bus.UpdPC[1:0]};

  // Next PC: redirects beat stalls
  always_comb begin
    pc_d = pc_q;
    if (bus.Exception)       pc_d = EXC_VECTOR;
    else if (bus.Mispredict) pc_d = bus.CorrectPC;
    else if (bus.PCWrite)    pc_d = pred_next_c;
  end

  // IF/ID next value: flush beats hold
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_pt_d    = ifid_pt_q;
    ifid_tgt_d   = ifid_tgt_q;
    ifid_valid_d = ifid_valid_q;
    if (flush_c) begin
      ifid_instr_d = '0;
      ifid_pc4_d   = '0;
      ifid_pt_d    = 1'b0;
      ifid_tgt_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (bus.IF_ID_Write) begin
      ifid_instr_d = bus.Instruction;
      ifid_pc4_d   = pc_plus4_c;
      ifid_pt_d    = pred_taken_c;
      ifid_tgt_d   = pred_next_c;
      ifid_valid_d = 1'b1;
    end
  end

  // Resolution update: train on hit, allocate on taken miss
  logic [IW-1:0]   upd_idx_c;
  logic [TAGW-1:0] upd_tag_c;
  logic            upd_hit_c;
  logic            upd_we_c;
  logic [TAGW-1:0] upd_tag_d;
  logic [XLEN-1:0] upd_tgt_d;
  logic [1:0]      upd_ctr_d;

  assign upd_idx_c = bus.UpdPC[IW+1:2];
  assign upd_tag_c = bus.UpdPC[XLEN-1:IW+2];
  assign upd_hit_c = btb_valid_q[upd_idx_c] && (btb_tag_q[upd_idx_c] == upd_tag_c);

  always_comb begin
    upd_we_c  = 1'b0;
    upd_tag_d = btb_tag_q[upd_idx_c];
    upd_tgt_d = btb_tgt_q[upd_idx_c];
    upd_ctr_d = btb_ctr_q[upd_idx_c];
    if (bus.UpdValid) begin
      if (upd_hit_c) begin
        upd_we_c = 1'b1;
        if (bus.UpdTaken) begin
          upd_tgt_d = bus.UpdTarget;
          if (btb_ctr_q[upd_idx_c] != 2'b11) upd_ctr_d = btb_ctr_q[upd_idx_c] + 2'b01;
        end else if (btb_ctr_q[upd_idx_c] != 2'b00) begin
          upd_ctr_d = btb_ctr_q[upd_idx_c] - 2'b01;
        end
      end else if (bus.UpdTaken) begin
        upd_we_c  = 1'b1;
        upd_tag_d = upd_tag_c;
        upd_tgt_d = bus.UpdTarget;
        upd_ctr_d = 2'b10;
      end
    end
  end

  // BTB storage; written regardless of stall/flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
        btb_ctr_q[i]   <= CTR_INIT;
      end
    end else if (upd_we_c) begin
      btb_valid_q[upd_idx_c] <= 1'b1;
      btb_tag_q[upd_idx_c]   <= upd_tag_d;
      btb_tgt_q[upd_idx_c]   <= upd_tgt_d;
      btb_ctr_q[upd_idx_c]   <= upd_ctr_d;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_pt_q    <= 1'b0;
      ifid_tgt_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_pt_q    <= ifid_pt_d;
      ifid_tgt_q   <= ifid_tgt_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.PCResult            = pc_q;
  assign bus.IF_ID_Instruction   = ifid_instr_q;
  assign bus.IF_ID_PCadderResult = ifid_pc4_q;
  assign bus.IF_ID_PredTaken     = ifid_pt_q;
  assign bus.IF_ID_PredTarget    = ifid_tgt_q;
  assign bus.IF_ID_Valid         = ifid_valid_q;

endmodule

// File: tb/tb_bpred_fetch_stage.sv
// Testbench for bpred_fetch_stage: directed scenarios with fixed expected
// values, followed by randomized traffic checked against a reference model.
module tb_bpred_fetch_stage;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IW      = 4;
  localparam logic [31:0] EXC     = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpred_fetch_stage_if #(.XLEN(32)) bus ();

  bpred_fetch_stage #(.XLEN(32), .ENTRIES(ENTRIES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int failures  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_iv;
  logic [31:0] m_ii, m_ipc, m_itgt;
  logic        m_ipt;
  logic        m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_ctr [ENTRIES];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_pc = 32'h0; m_iv = 1'b0; m_ii = '0; m_ipc = '0; m_itgt = '0; m_ipt = 1'b0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
  endfunction

  task automatic set_ctl(input logic pcw, input logic ifw, input logic exc,
                         input logic mis, input logic [31:0] cpc);
    bus.PCWrite = pcw; bus.IF_ID_Write = ifw; bus.Exception = exc;
    bus.Mispredict = mis; bus.CorrectPC = cpc;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt);
    bus.UpdValid = v; bus.UpdPC = pc; bus.UpdTaken = tk; bus.UpdTarget = tgt;
  endtask

  // Advance one clock, stepping the model with the inputs currently driven
  task automatic tick();
    int li, ui;
    logic [31:0] lt, ut, pn, npc;
    logic pt;
    bus.Instruction = $urandom();
    li = int'((m_pc >> 2) % ENTRIES);
    lt = m_pc >> (IW + 2);
    pt = m_v[li] && (m_tag[li] == lt) && (m_ctr[li] >= 2);
    pn = pt ? m_tgt[li] : m_pc + 32'd4;
    if (bus.Exception)       npc = EXC;
    else if (bus.Mispredict) npc = bus.CorrectPC;
    else if (bus.PCWrite)    npc = pn;
    else                     npc = m_pc;
    if (bus.Exception || bus.Mispredict) begin
      m_iv = 1'b0; m_ii = '0; m_ipc = '0; m_ipt = 1'b0; m_itgt = '0;
    end else if (bus.IF_ID_Write) begin
      m_iv = 1'b1; m_ii = bus.Instruction; m_ipc = m_pc + 32'd4; m_ipt = pt; m_itgt = pn;
    end
    if (bus.UpdValid) begin
      ui = int'((bus.UpdPC >> 2) % ENTRIES);
      ut = bus.UpdPC >> (IW + 2);
      if (m_v[ui] && m_tag[ui] == ut) begin
        if (bus.UpdTaken) begin
          m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
          m_tgt[ui] = bus.UpdTarget;
        end else begin
          m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
      end else if (bus.UpdTaken) begin
        m_v[ui] = 1'b1; m_tag[ui] = ut; m_tgt[ui] = bus.UpdTarget; m_ctr[ui] = 2;
      end
    end
    m_pc = npc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    set_upd(1'b0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    set_upd(1'b0, '0, 1'b0, '0);
    bus.Instruction = '0;
    #2;
    tests_run++;
    if (bus.PCResult !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want %h", bus.PCResult, 32'h0); end
    tests_run++;
    if (bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instruction !== 32'h0 || bus.IF_ID_PCadderResult !== 32'h0)
      begin failures++; $display("FAIL reset_ifid: valid %b instr %h pc4 %h want 0", bus.IF_ID_Valid, bus.IF_ID_Instruction, bus.IF_ID_PCadderResult); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    tests_run++;
    if (bus.IF_ID_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid_before_edge: got %b want 0", bus.IF_ID_Valid); end
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h4 || bus.IF_ID_PCadderResult !== 32'h4 || bus.IF_ID_Valid !== 1'b1)
      begin failures++; $display("FAIL seq_fetch1: pc %h pc4 %h valid %b want 4 4 1", bus.PCResult, bus.IF_ID_PCadderResult, bus.IF_ID_Valid); end
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h8 || bus.IF_ID_PCadderResult !== 32'h8)
      begin failures++; $display("FAIL seq_fetch2: pc %h pc4 %h want 8 8", bus.PCResult, bus.IF_ID_PCadderResult); end
  endtask

  task automatic test_reset_mid_redirect();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.PCResult !== 32'h0 || bus.IF_ID_Valid !== 1'b0)
      begin failures++; $display("FAIL reset_mid_redirect: pc %h valid %b want 0 0", bus.PCResult, bus.IF_ID_Valid); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h4) begin failures++; $display("FAIL reset_release_fetch: got %h want %h", bus.PCResult, 32'h4); end
  endtask

  task automatic test_allocate_predict();
    do_reset();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    tick(); tick(); tick();
    tests_run++;
    if (bus.PCResult !== 32'h10) begin failures++; $display("FAIL alloc_reach: got %h want %h", bus.PCResult, 32'h10); end
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h40) begin failures++; $display("FAIL alloc_next_pc: got %h want %h", bus.PCResult, 32'h40); end
    tests_run++;
    if (bus.IF_ID_PredTaken !== 1'b1 || bus.IF_ID_PredTarget !== 32'h40 || bus.IF_ID_PCadderResult !== 32'h14)
      begin failures++; $display("FAIL alloc_ifid: pt %b tgt %h pc4 %h want 1 40 14", bus.IF_ID_PredTaken, bus.IF_ID_PredTarget, bus.IF_ID_PCadderResult); end
  endtask

  // Holds PC at 0x10 and captures each edge's prediction into IF/ID
  task automatic test_saturation();
    int   kind [11];
    logic expt [11];
    logic [31:0] et;
    kind = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 0, 2};
    expt = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    tick();
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 11; i++) begin
      if (kind[i] == 2) set_upd(1'b0, '0, 1'b0, '0);
      else              set_upd(1'b1, 32'h10, kind[i] == 1, 32'h40);
      tick();
      et = expt[i] ? 32'h40 : 32'h14;
      tests_run++;
      if (bus.IF_ID_PredTaken !== expt[i] || bus.IF_ID_PredTarget !== et)
        begin failures++; $display("FAIL saturation_step%0d: pt %b tgt %h want %b %h", i, bus.IF_ID_PredTaken, bus.IF_ID_PredTarget, expt[i], et); end
    end
    set_upd(1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_mispredict_stall();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h80 || bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instruction !== 32'h0 || bus.IF_ID_PredTaken !== 1'b0)
      begin failures++; $display("FAIL mispredict_stall: pc %h valid %b instr %h pt %b want 80 0 0 0", bus.PCResult, bus.IF_ID_Valid, bus.IF_ID_Instruction, bus.IF_ID_PredTaken); end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h80 || bus.IF_ID_Valid !== 1'b0)
      begin failures++; $display("FAIL stall_hold: pc %h valid %b want 80 0", bus.PCResult, bus.IF_ID_Valid); end
  endtask

  task automatic test_exception_priority();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    tick();
    tests_run++;
    if (bus.PCResult !== EXC || bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_PCadderResult !== 32'h0 || bus.IF_ID_PredTarget !== 32'h0)
      begin failures++; $display("FAIL exc_priority: pc %h valid %b pc4 %h tgt %h want 100 0 0 0", bus.PCResult, bus.IF_ID_Valid, bus.IF_ID_PCadderResult, bus.IF_ID_PredTarget); end
  endtask

  task automatic test_alias_bypass();
    do_reset();
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    tick();
    set_upd(1'b1, 32'h50, 1'b1, 32'h90);
    tick();
    set_upd(1'b0, '0, 1'b0, '0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h14 || bus.IF_ID_PredTaken !== 1'b0)
      begin failures++; $display("FAIL alias_evicted: pc %h pt %b want 14 0", bus.PCResult, bus.IF_ID_PredTaken); end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h50);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h90 || bus.IF_ID_PredTaken !== 1'b1)
      begin failures++; $display("FAIL alias_new_hit: pc %h pt %b want 90 1", bus.PCResult, bus.IF_ID_PredTaken); end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, '0);
    set_upd(1'b1, 32'h20, 1'b1, 32'h60);
    tick();
    tests_run++;
    if (bus.IF_ID_PredTaken !== 1'b0 || bus.IF_ID_PredTarget !== 32'h24)
      begin failures++; $display("FAIL bypass_old: pt %b tgt %h want 0 24", bus.IF_ID_PredTaken, bus.IF_ID_PredTarget); end
    set_upd(1'b0, '0, 1'b0, '0);
    tick();
    tests_run++;
    if (bus.IF_ID_PredTaken !== 1'b1 || bus.IF_ID_PredTarget !== 32'h60)
      begin failures++; $display("FAIL bypass_new: pt %b tgt %h want 1 60", bus.IF_ID_PredTaken, bus.IF_ID_PredTarget); end
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h60) begin failures++; $display("FAIL bypass_redirect: got %h want %h", bus.PCResult, 32'h60); end
  endtask

  task automatic test_wrap();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, '0);
    tick();
    tests_run++;
    if (bus.PCResult !== 32'h0 || bus.IF_ID_PCadderResult !== 32'h0)
      begin failures++; $display("FAIL wrap: pc %h pc4 %h want 0 0", bus.PCResult, bus.IF_ID_PCadderResult); end
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 7) == 0) p = p | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) p = p | 32'hFFFF_FF00;
    return p;
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, pick_pc());
      set_upd($urandom_range(0, 1) == 1, pick_pc(), $urandom_range(0, 1) == 1, pick_pc());
      tick();
      tests_run++;
      if (bus.PCResult !== m_pc) begin failures++; $display("FAIL rand_pc[%0d]: got %h want %h", n, bus.PCResult, m_pc); end
      tests_run++;
      if (bus.IF_ID_Valid !== m_iv || bus.IF_ID_Instruction !== m_ii)
        begin failures++; $display("FAIL rand_ifid_instr[%0d]: valid %b instr %h want %b %h", n, bus.IF_ID_Valid, bus.IF_ID_Instruction, m_iv, m_ii); end
      tests_run++;
      if (bus.IF_ID_PCadderResult !== m_ipc) begin failures++; $display("FAIL rand_ifid_pc4[%0d]: got %h want %h", n, bus.IF_ID_PCadderResult, m_ipc); end
      tests_run++;
      if (bus.IF_ID_PredTaken !== m_ipt || bus.IF_ID_PredTarget !== m_itgt)
        begin failures++; $display("FAIL rand_ifid_pred[%0d]: pt %b tgt %h want %b %h", n, bus.IF_ID_PredTaken, bus.IF_ID_PredTarget, m_ipt, m_itgt); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_redirect();
    test_allocate_predict();
    test_saturation();
    test_mispredict_stall();
    test_exception_priority();
    test_alias_bypass();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/bpred_fetch_stage.md
Name: bpred_fetch_stage

Overview:
- Parametrised instruction-fetch stage for the 5-stage MIPS pipeline.
- Replaces the fixed PC / PC+4 / IF-ID path with:
  - a direct-mapped branch target buffer (BTB);
  - a 2-bit saturating-counter predictor;
  - a registered IF/ID output carrying the prediction.
- Sits between instruction memory and the decode stage.
- Decode-stage branch resolution feeds back through the update and mispredict ports.

Parameters:
- XLEN, 32: address/instruction width.
- ENTRIES, 16: BTB/predictor entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC after reset.
- EXC_VECTOR, 32'h0000_0100: exception target.
- CTR_INIT, 2'b01: counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCWrite  in  1  1 = PC may advance; 0 = stall.
- IF_ID_Write  in  1  1 = IF/ID register may load; 0 = hold.
- Exception  in  1  redirect to EXC_VECTOR and flush IF/ID.
- Mispredict  in  1  redirect to CorrectPC and flush IF/ID.
- CorrectPC  in  XLEN  recovery PC, valid when Mispredict=1.
- UpdValid  in  1  resolved branch in ID this cycle.
- UpdPC  in  XLEN  PC of the resolved branch.
- UpdTaken  in  1  actual branch outcome.
- UpdTarget  in  XLEN  actual branch target.
- PCResult  out  XLEN  current PC; drives instruction-memory address.
- Instruction  in  32  instruction-memory read data (combinational).
- IF_ID_Instruction  out  32  latched instruction.
- IF_ID_PCadderResult  out  XLEN  latched PC+4.
- IF_ID_PredTaken  out  1  latched prediction.
- IF_ID_PredTarget  out  XLEN  latched predicted next PC.
- IF_ID_Valid  out  1  0 = bubble.

Behaviour:
- Indexing:
  - IW = log2(ENTRIES).
  - idx = PC[IW+1:2]; tag = PC[XLEN-1:IW+2].
  - PC[1:0] is ignored.
- Entry contents: valid bit, tag, target, 2-bit counter.
- Lookup (combinational, on PCResult):
  - hit = valid && tag match.
  - PredTaken = hit && ctr[1].
  - PredNext = PredTaken ? target : PCResult+4.
- Next-PC priority, evaluated at every edge:
  1. Exception -> EXC_VECTOR.
  2. Mispredict -> CorrectPC.
  3. PCWrite=1 -> PredNext.
  4. Otherwise hold.
- Redirects (Exception or Mispredict) override PCWrite=0.
- IF/ID register priority:
  1. Flush (Exception | Mispredict): Valid=0, Instruction=0 (sll nop), PredTaken=0, other fields 0. Overrides IF_ID_Write=0.
  2. IF_ID_Write=1: capture Instruction, PCResult+4, PredTaken, PredNext; Valid=1.
  3. Otherwise hold all fields.
- Update (at the edge where UpdValid=1):
  - Entry selected by UpdPC.
  - If tag matches and entry is valid: counter saturating-increments on UpdTaken, saturating-decrements otherwise (3 stays 3, 0 stays 0). If UpdTaken, also rewrite the target.
  - If miss and UpdTaken: allocate the entry (valid=1, new tag, target=UpdTarget, ctr=2'b10), overwriting any occupant.
  - If miss and not taken: no change.
- Update is independent of stall and flush.
- Same-edge update and lookup of one index: the lookup sees the pre-update value (no bypass).
- Latency:
  - Prediction is zero-cycle (same cycle as fetch).
  - Update is visible on the cycle after the edge.
- Reset (asynchronous, rst=0):
  - PCResult = RESET_PC.
  - All entry valid bits = 0; all counters = CTR_INIT; targets and tags = 0.
  - All IF_ID outputs = 0, IF_ID_Valid = 0.
  - Reset mid-stall or mid-redirect: reset wins; the next rising edge after release fetches RESET_PC+4 (PCWrite=1).
- Wrap-around: PC+4 wraps modulo 2^XLEN.
- Targets are stored as given; no alignment check.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: rst low then high, PCWrite=IF_ID_Write=1, empty BTB.
  - Required response: PCResult sequence 0, 4, 8; IF_ID_PCadderResult lags by one cycle; IF_ID_Valid=0 until the first edge.
- Allocate and predict:
  - Stimulus: UpdValid with UpdPC=0x10, taken, target 0x40; later fetch PC=0x10.
  - Required response: next PC 0x40; IF_ID_PredTaken=1; IF_ID_PredTarget=0x40.
- Counter saturation:
  - Stimulus: from 2'b10, four not-taken updates at 0x10, then four taken.
  - Required response: prediction goes not-taken after the first update; the counter sticks at 0; predicting taken requires two taken updates; the counter sticks at 3.
- Mispredict during stall:
  - Stimulus: PCWrite=0, IF_ID_Write=0, Mispredict=1, CorrectPC=0x80.
  - Required response: PCResult=0x80 next cycle; IF_ID_Valid=0; IF_ID_Instruction=0.
- Exception vs mispredict:
  - Stimulus: both asserted in one cycle.
  - Required response: PCResult=0x100; IF/ID flushed.
- Aliasing and same-index bypass:
  - Stimulus with ENTRIES=16: allocate 0x10, then allocate 0x50 (same idx, different tag).
  - Required response: 0x10 now misses.
  - Stimulus: an update at an index during the same cycle that index is looked up.
  - Required response: old prediction used that cycle; new one used the cycle after.
